// File: rtl/byte_strip_pkg.sv
// byte_strip_pkg: shared definitions for the byte_strip_n framer.
//   - K-symbol codes (8-bit, zero-extended to the symbol width on compare)
//   - framing error codes reported on ERR_CODE
//   - framer states and the symbol classes produced by byte_strip_decode
package byte_strip_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_START = 2'd1,
    ERR_END   = 2'd2,
    ERR_SYM   = 2'd3
  } err_code_t;

  typedef enum logic {
    IDLE   = 1'b0,
    PACKET = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CLS_DATA,
    CLS_START,
    CLS_END,
    CLS_FILLER,
    CLS_ILLEGAL
  } sym_class_t;

endpackage

// File: rtl/byte_strip_decode.sv
// byte_strip_decode: combinational symbol classifier.
//   d         : symbol value (BITS wide)
//   dk        : 1 = control (K) symbol
//   sym_class : data / start (STP,SDP) / end (END,EDB) /
//               filler (COM,SKP,IDL) / illegal (PAD or unknown K)
module byte_strip_decode
  import byte_strip_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] d,
  input  logic            dk,
  output sym_class_t      sym_class
);

  // K codes are 8-bit; any set bit above bit 7 makes the symbol unknown.
  logic upper_clear;
  assign upper_clear = ((d >> 8) == '0);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sym_class = CLS_DATA;
    if (dk) begin
      sym_class = CLS_ILLEGAL;
      if (upper_clear) begin
        case (d[7:0])
          K_STP, K_SDP:        sym_class = CLS_START;
          K_END, K_EDB:        sym_class = CLS_END;
          K_COM, K_SKP, K_IDL: sym_class = CLS_FILLER;
          default:             sym_class = CLS_ILLEGAL;
        endcase
      end
    end
  end

endmodule

// File: rtl/byte_strip_n.sv
// byte_strip_n: byte-striping framer. Takes one symbol per cycle, checks
// packet framing and releases each completed group of LANES symbols to all
// lanes in parallel.
//   CLK        : clock, rising edge
//   RESET      : synchronous reset, active-high
//   D_VALID    : D/DK carry a symbol this cycle
//   D, DK      : symbol and its K flag
//   LANE_DATA  : lane i at [i*BITS +: BITS], held until the next release
//   LANE_DK    : per-lane K flag
//   LANE_VALID : one-cycle pulse when a new group is presented
//   ERROR      : one-cycle pulse on a framing violation
//   ERR_CODE   : cause while ERROR=1, otherwise 0
//   IN_PKT     : framer is inside a packet
// Build option: define BYTE_STRIP_PAD_EN to accept an early END/EDB inside a
// packet, filling the rest of the group with PAD instead of flagging ERR_END.
module byte_strip_n
  import byte_strip_pkg::*;
#(
  parameter int LANES = 4,
  parameter int BITS  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  D_VALID,
  input  logic [BITS-1:0]       D,
  input  logic                  DK,
  output logic [LANES*BITS-1:0] LANE_DATA,
  output logic [LANES-1:0]      LANE_DK,
  output logic                  LANE_VALID,
  output logic                  ERROR,
  output logic [1:0]            ERR_CODE,
  output logic                  IN_PKT
);

  localparam int              CW   = $clog2(LANES);
  localparam logic [CW-1:0]   LAST = CW'(LANES - 1);

  state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  sym_class_t sym_class;
  logic       at_last;
  logic       accept;
  logic       pad_tail;
  logic       release_grp;
  logic       err;
  err_code_t  err_code;

  logic [BITS-1:0]       shadow_d [LANES];
  logic [LANES-1:0]      shadow_k;
  logic [LANES*BITS-1:0] group_d;
  logic [LANES-1:0]      group_k;

  byte_strip_decode #(.BITS(BITS)) u_decode (
    .d         (D),
    .dk        (DK),
    .sym_class (sym_class)
  );

  assign at_last     = (cnt == LAST);
  assign release_grp = accept && (at_last || pad_tail);
  assign IN_PKT      = (state == PACKET);

  // Framing rules: decide accept / error / next state for the current symbol.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pad_tail  = 1'b0;
    err       = 1'b0;
    err_code  = ERR_NONE;
    if (D_VALID) begin
      case (state)
        IDLE: begin
          case (sym_class)
            CLS_FILLER: accept = 1'b1;
            CLS_START: begin
              if (cnt == '0) begin
                accept    = 1'b1;
                state_nxt = PACKET;
              end else begin
                err      = 1'b1;
                err_code = ERR_START;
              end
            end
            CLS_END: begin
              err      = 1'b1;
              err_code = ERR_END;
            end
            default: begin
              err      = 1'b1;
              err_code = ERR_SYM;
            end
          endcase
        end
        PACKET: begin
          case (sym_class)
            CLS_DATA: accept = 1'b1;
            CLS_END: begin
              if (at_last) begin
                accept    = 1'b1;
                state_nxt = IDLE;
              end else begin
`ifdef BYTE_STRIP_PAD_EN
                accept    = 1'b1;
                pad_tail  = 1'b1;
                state_nxt = IDLE;
`else
                err      = 1'b1;
                err_code = ERR_END;
`endif
              end
            end
            CLS_START: begin
              err      = 1'b1;
              err_code = ERR_START;
            end
            default: begin
              err      = 1'b1;
              err_code = ERR_SYM;
            end
          endcase
        end
        default: state_nxt = IDLE;
      endcase
      // Any violation resynchronises to IDLE.
      if (err) state_nxt = IDLE;
    end
  end

  // Group being released: shadow slots, the current symbol at slot cnt and,
  // for an early end, PAD in every slot after it.
  always_comb begin
    group_d = '0;
    group_k = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) == cnt) begin
        group_d[i*BITS +: BITS] = D;
        group_k[i]              = DK;
      end else if (pad_tail && (CW'(i) > cnt)) begin
        group_d[i*BITS +: BITS] = BITS'(K_PAD);
        group_k[i]              = 1'b1;
      end else begin
        group_d[i*BITS +: BITS] = shadow_d[i];
        group_k[i]              = shadow_k[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      // NOTE: the shadow is small and explicitly defined at reset, so it is
      // cleared element by element; larger RAM-style arrays would not be.
      for (int i = 0; i < LANES; i++) shadow_d[i] <= '0;
      shadow_k   <= '0;
      LANE_DATA  <= '0;
      LANE_DK    <= '0;
      LANE_VALID <= 1'b0;
      ERROR      <= 1'b0;
      ERR_CODE   <= 2'd0;
    end else begin
      LANE_VALID <= release_grp;
      ERROR      <= err;
      ERR_CODE   <= err_code;
      if (err) begin
        cnt <= '0;
      end else if (accept) begin
        shadow_d[cnt] <= D;
        shadow_k[cnt] <= DK;
        cnt           <= release_grp ? '0 : cnt + 1'b1;
      end
      if (release_grp) begin
        LANE_DATA <= group_d;
        LANE_DK   <= group_k;
      end
    end
  end

endmodule

// File: tb/tb_byte_strip_n.sv
// tb_byte_strip_n: scoreboard bench for byte_strip_n.
// Two instances: dut_a (LANES=4, BITS=8) and dut_b (LANES=8, BITS=10).
// Expected groups / errors are queued as stimulus is driven and popped when
// the DUT pulses LANE_VALID or ERROR. Honours BYTE_STRIP_PAD_EN.
module tb_byte_strip_n;

  typedef struct {
    bit           is_err;
    logic [127:0] data;
    logic [15:0]  dk;
    logic [1:0]   code;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        a_reset, a_dv, a_dk;
  logic [7:0]  a_d;
  logic [31:0] a_lane_data;
  logic [3:0]  a_lane_dk;
  logic        a_valid, a_error, a_in_pkt;
  logic [1:0]  a_err_code;

  logic        b_reset, b_dv, b_dk;
  logic [9:0]  b_d;
  logic [79:0] b_lane_data;
  logic [7:0]  b_lane_dk;
  logic        b_valid, b_error, b_in_pkt;
  logic [1:0]  b_err_code;

  byte_strip_n #(.LANES(4), .BITS(8)) dut_a (
    .CLK(CLK), .RESET(a_reset), .D_VALID(a_dv), .D(a_d), .DK(a_dk),
    .LANE_DATA(a_lane_data), .LANE_DK(a_lane_dk), .LANE_VALID(a_valid),
    .ERROR(a_error), .ERR_CODE(a_err_code), .IN_PKT(a_in_pkt)
  );

  byte_strip_n #(.LANES(8), .BITS(10)) dut_b (
    .CLK(CLK), .RESET(b_reset), .D_VALID(b_dv), .D(b_d), .DK(b_dk),
    .LANE_DATA(b_lane_data), .LANE_DK(b_lane_dk), .LANE_VALID(b_valid),
    .ERROR(b_error), .ERR_CODE(b_err_code), .IN_PKT(b_in_pkt)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t grp(input logic [127:0] d, input logic [15:0] k);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.dk = k; e.code = 2'd0;
    return e;
  endfunction

  function automatic exp_t erc(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.data = '0; e.dk = '0; e.code = c;
    return e;
  endfunction

  // Scoreboard monitors, sampling 1 time unit after the active edge.
  always @(posedge CLK) begin
    #1;
    if (a_valid) begin
      if (q_a.size() == 0) check("a_spurious_group", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_group_kind", 0, ea.is_err);
        if (!ea.is_err) begin
          check("a_lane_data", a_lane_data, ea.data);
          check("a_lane_dk", a_lane_dk, ea.dk);
        end
      end
    end
    if (a_error) begin
      if (q_a.size() == 0) check("a_spurious_error", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_error_kind", 1, ea.is_err);
        if (ea.is_err) check("a_err_code", a_err_code, ea.code);
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (b_valid) begin
      if (q_b.size() == 0) check("b_spurious_group", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_group_kind", 0, eb.is_err);
        if (!eb.is_err) begin
          check("b_lane_data", b_lane_data, eb.data);
          check("b_lane_dk", b_lane_dk, eb.dk);
        end
      end
    end
    if (b_error) begin
      if (q_b.size() == 0) check("b_spurious_error", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_error_kind", 1, eb.is_err);
        if (eb.is_err) check("b_err_code", b_err_code, eb.code);
      end
    end
  end

  // Inputs change on the falling edge; each call is one accepted-slot cycle.
  task automatic send_a(input logic [7:0] d, input logic k);
    a_dv = 1'b1; a_d = d; a_dk = k;
    @(negedge CLK);
    a_dv = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] d, input logic k);
    b_dv = 1'b1; b_d = d; b_dk = k;
    @(negedge CLK);
    b_dv = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (q_a.size() != 0 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check(tag, q_a.size(), 0);
  endtask

  task automatic drain_b(input string tag);
    int n = 0;
    while (q_b.size() != 0 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check(tag, q_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [79:0] bd;
    logic [7:0]  bk;
    logic [9:0]  sym;
    logic        k;

    a_reset = 1'b1; a_dv = 1'b0; a_d = '0; a_dk = 1'b0;
    b_reset = 1'b1; b_dv = 1'b0; b_d = '0; b_dk = 1'b0;
    repeat (2) @(negedge CLK);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Reset state
    check("rst_a_lane_data", a_lane_data, 0);
    check("rst_a_lane_dk", a_lane_dk, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_error", a_error, 0);
    check("rst_a_err_code", a_err_code, 0);
    check("rst_a_in_pkt", a_in_pkt, 0);
    check("rst_b_lane_data", b_lane_data, 0);

    // Filler group, then a two-group packet
    q_a.push_back(grp(32'h7C7C7C7C, 4'b1111));
    repeat (4) send_a(8'h7C, 1'b1);
    send_a(8'hFB, 1'b1);
    check("t1_in_pkt_after_stp", a_in_pkt, 1);
    send_a(8'h11, 1'b0);
    send_a(8'h22, 1'b0);
    q_a.push_back(grp(32'h332211FB, 4'b0001));
    send_a(8'h33, 1'b0);
    send_a(8'h44, 1'b0);
    send_a(8'h55, 1'b0);
    send_a(8'h66, 1'b0);
    q_a.push_back(grp(32'hFD665544, 4'b1000));
    send_a(8'hFD, 1'b1);
    check("t1_in_pkt_after_end", a_in_pkt, 0);
    drain_a("t1_drain");

    // Misplaced start, resync at lane 0, then illegal K in a packet
    send_a(8'h7C, 1'b1);
    q_a.push_back(erc(2'd1));
    send_a(8'hFB, 1'b1);
    check("t2_in_pkt_after_err", a_in_pkt, 0);
    send_a(8'hFB, 1'b1);
    check("t2_in_pkt_resync", a_in_pkt, 1);
    q_a.push_back(erc(2'd3));
    send_a(8'h1C, 1'b1);
    check("t2_in_pkt_after_skp", a_in_pkt, 0);
    drain_a("t2_drain");

    // Early END at lane 2
    send_a(8'hFB, 1'b1);
    send_a(8'h01, 1'b0);
`ifdef BYTE_STRIP_PAD_EN
    q_a.push_back(grp(32'hF7FD01FB, 4'b1101));
`else
    q_a.push_back(erc(2'd2));
`endif
    send_a(8'hFD, 1'b1);
    check("t3_in_pkt", a_in_pkt, 0);
    drain_a("t3_drain");

    // IDLE violations: data, END, EDB, PAD, unknown K
    q_a.push_back(erc(2'd3)); send_a(8'hAA, 1'b0);
    q_a.push_back(erc(2'd2)); send_a(8'hFD, 1'b1);
    q_a.push_back(erc(2'd2)); send_a(8'hFE, 1'b1);
    q_a.push_back(erc(2'd3)); send_a(8'hF7, 1'b1);
    q_a.push_back(erc(2'd3)); send_a(8'h00, 1'b1);
    drain_a("t4_drain");

    // SDP with bubbles, output hold, then END at lane 0
    send_a(8'h5C, 1'b1);
    repeat (3) @(negedge CLK);
    check("t5_in_pkt_bubbles", a_in_pkt, 1);
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    q_a.push_back(grp(32'h0302015C, 4'b0001));
    send_a(8'h03, 1'b0);
    repeat (2) @(negedge CLK);
    check("t5_data_hold", a_lane_data, 32'h0302015C);
`ifdef BYTE_STRIP_PAD_EN
    q_a.push_back(grp(32'hF7F7F7FD, 4'b1111));
`else
    q_a.push_back(erc(2'd2));
`endif
    send_a(8'hFD, 1'b1);
    drain_a("t5_drain");

    // Reset mid-packet, coinciding with a symbol that would complete a group
    send_a(8'hFB, 1'b1);
    send_a(8'h10, 1'b0);
    send_a(8'h20, 1'b0);
    a_reset = 1'b1; a_dv = 1'b1; a_d = 8'h30; a_dk = 1'b0;
    @(negedge CLK);
    a_reset = 1'b0; a_dv = 1'b0;
    check("t6_lane_data", a_lane_data, 0);
    check("t6_lane_dk", a_lane_dk, 0);
    check("t6_valid", a_valid, 0);
    check("t6_error", a_error, 0);
    check("t6_err_code", a_err_code, 0);
    check("t6_in_pkt", a_in_pkt, 0);
    send_a(8'hFB, 1'b1);
    send_a(8'h0A, 1'b0);
    send_a(8'h0B, 1'b0);
    q_a.push_back(grp(32'h0C0B0AFB, 4'b0001));
    send_a(8'h0C, 1'b0);
    send_a(8'hD1, 1'b0);
    send_a(8'hD2, 1'b0);
    send_a(8'hD3, 1'b0);
    q_a.push_back(grp(32'hFED3D2D1, 4'b1000));
    send_a(8'hFE, 1'b1);
    drain_a("t6_drain");

    // Eight lanes of 10-bit symbols
    for (int g = 0; g < 2; g++) begin
      bd = '0;
      bk = '0;
      for (int i = 0; i < 8; i++) begin
        if (g == 0 && i == 0)      begin sym = 10'h0FB; k = 1'b1; end
        else if (g == 1 && i == 7) begin sym = 10'h0FD; k = 1'b1; end
        else                       begin sym = 10'h300 + 10'(g * 8 + i); k = 1'b0; end
        bd[i*10 +: 10] = sym;
        bk[i]          = k;
        if (i == 7) q_b.push_back(grp({48'd0, bd}, {8'd0, bk}));
        send_b(sym, k);
      end
    end
    check("t7_in_pkt", b_in_pkt, 0);
    drain_b("t7_drain");

    // Upper bits set on a K symbol make it unknown
    q_b.push_back(erc(2'd3));
    send_b(10'h1FB, 1'b1);
    drain_b("t7_wide_k_drain");
    send_b(10'h0FB, 1'b1);
    check("t7_in_pkt_stp", b_in_pkt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
